// File: rtl/sram_port_sequencer_pkg.sv
// Shared definitions for the SRAM port sequencer.
//   ADDR_W_DEF / DATA_W_DEF : default macro address / word widths
//   WMODE_READ / WMODE_WRITE: encoding of the macro's sram_wmode pin
//   RESP_DEPTH              : number of read responses that can be held
//   pref_e                  : round-robin preference between the channels
//   read_credit_ok()        : whether one more read may be issued this cycle
package sram_port_sequencer_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 66;

  localparam logic WMODE_READ  = 1'b0;
  localparam logic WMODE_WRITE = 1'b1;

  // The response FIFO uses 1-bit wrapping pointers, so this stays at 2.
  localparam int RESP_DEPTH = 2;
  localparam int OCC_W      = 2;

  typedef enum logic {
    PREF_WRITE = 1'b0,
    PREF_READ  = 1'b1
  } pref_e;

  // A new read needs a guaranteed slot when its data lands two cycles from
  // now: count what is buffered plus what is in flight, minus what leaves
  // this cycle. pop only happens with occ > 0, so the sum never underflows.
  function automatic logic read_credit_ok(input logic [OCC_W-1:0] occ,
                                          input logic             infl,
                                          input logic             pop);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    return sum < 3'(RESP_DEPTH);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry valid/ready FIFO holding read data captured from the SRAM macro.
//   clock, reset_n : clock and asynchronous active-low reset
//   push_valid     : capture push_data this cycle (caller guarantees room)
//   push_data      : data to store
//   pop_valid      : head entry present
//   pop_ready      : consumer takes the head entry
//   pop_data       : head entry, 0 when empty
//   occ            : number of stored entries (0..2)
module sram_resp_fifo
  import sram_port_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem_reg [RESP_DEPTH];
  logic              rd_ptr_reg;
  logic              wr_ptr_reg;
  logic [OCC_W-1:0]  occ_reg;
  logic [OCC_W-1:0]  occ_next;
  logic              pop;

  assign pop_valid = (occ_reg != '0);
  assign pop       = pop_valid & pop_ready;
  assign pop_data  = pop_valid ? mem_reg[rd_ptr_reg] : '0;
  assign occ       = occ_reg;

  always_comb begin
    occ_next = occ_reg + OCC_W'(push_valid) - OCC_W'(pop);
  end

  // Push while full is legal only together with a pop: the write lands in
  // the slot being vacated, which is read before this edge updates it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      occ_reg    <= '0;
    end else begin
      if (push_valid) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_next;
    end
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(push_valid && occ_reg == OCC_W'(RESP_DEPTH) && !pop));

endmodule

// File: rtl/sram_port_sequencer.sv
// Front-end merging a write channel and a read channel onto the single RW
// port of a synchronous SRAM macro (1-cycle read latency), returning read
// data on a valid/ready response channel backed by a 2-entry buffer.
//   clock, reset_n              : clock and asynchronous active-low reset
//   wreq_valid/ready/addr/data  : write request channel
//   rreq_valid/ready/addr       : read request channel
//   rresp_valid/ready/data      : read response channel
//   sram_en/wmode/addr/wdata    : combinational drive of the macro port
//   sram_rdata                  : macro read data (valid the cycle after a read)
module sram_port_sequencer
  import sram_port_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [DATA_W-1:0] wreq_data,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  output logic              rresp_valid,
  input  logic              rresp_ready,
  output logic [DATA_W-1:0] rresp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  pref_e            pref_reg;
  pref_e            pref_next;
  logic             infl_reg;
  logic             grant_w;
  logic             grant_r;
  logic             read_ok;
  logic             pop;
  logic [OCC_W-1:0] occ;

  assign pop     = rresp_valid & rresp_ready;
  assign read_ok = read_credit_ok(occ, infl_reg, pop);

  // State register: round-robin preference and the read-in-flight flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pref_reg <= PREF_WRITE;
      infl_reg <= 1'b0;
    end else begin
      pref_reg <= pref_next;
      infl_reg <= grant_r;
    end
  end

  // Next-state / grant logic. Grants are forced off while reset is asserted
  // so the macro port reads all-zero during reset, not just after it.
  always_comb begin
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    pref_next = pref_reg;
    if (reset_n) begin
      if (wreq_valid && rreq_valid) begin
        if (read_ok) begin
          if (pref_reg == PREF_WRITE) begin
            grant_w   = 1'b1;
            pref_next = PREF_READ;
          end else begin
            grant_r   = 1'b1;
            pref_next = PREF_WRITE;
          end
        end else begin
          // No credit for the read: the write goes ahead without using up
          // the read channel's turn.
          grant_w = 1'b1;
        end
      end else if (wreq_valid) begin
        grant_w = 1'b1;
      end else if (rreq_valid) begin
        grant_r = read_ok;
      end
    end
  end

  // Output logic: macro port driven straight from the grant.
  always_comb begin
    sram_en    = grant_w | grant_r;
    sram_wmode = grant_w ? WMODE_WRITE : WMODE_READ;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_w) begin
      sram_addr  = wreq_addr;
      sram_wdata = wreq_data;
    end else if (grant_r) begin
      sram_addr = rreq_addr;
    end
  end

  assign wreq_ready = grant_w;
  assign rreq_ready = grant_r;

  // Read data is valid the cycle after the grant, i.e. while infl_reg is set.
  sram_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (infl_reg),
    .push_data  (sram_rdata),
    .pop_valid  (rresp_valid),
    .pop_ready  (rresp_ready),
    .pop_data   (rresp_data),
    .occ        (occ)
  );

endmodule

// File: doc/sram_port_sequencer.md
Name: sram_port_sequencer

Overview:
- Upstream/downstream front-end for a single-port synchronous SRAM macro (one shared RW port, 1-cycle read latency, read data driven from a registered read address).
- Merges independent write and read request channels onto the single port, one access per cycle.
- Captures the macro's read data and returns it on a valid/ready response channel, with a 2-entry response buffer so backpressure never loses data.

Parameters:
- ADDR_W, 2, SRAM address width (depth = 2^ADDR_W)
- DATA_W, 66, SRAM word width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wreq_valid  in  1  write request valid
- wreq_ready  out  1  write request accepted this cycle
- wreq_addr  in  ADDR_W  write address
- wreq_data  in  DATA_W  write data
- rreq_valid  in  1  read request valid
- rreq_ready  out  1  read request accepted this cycle
- rreq_addr  in  ADDR_W  read address
- rresp_valid  out  1  read response valid
- rresp_ready  in  1  consumer accepts response
- rresp_data  out  DATA_W  read response data
- sram_en  out  1  to macro enable
- sram_wmode  out  1  to macro: 1 = write, 0 = read
- sram_addr  out  ADDR_W  to macro address
- sram_wdata  out  DATA_W  to macro write data
- sram_rdata  in  DATA_W  from macro read data

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Clears the in-flight flag, response buffer, and round-robin pointer. The pointer resets to favour write.
  - Outputs during and after reset: rresp_valid=0, rresp_data=0, sram_en=0, sram_wmode=0, sram_addr=0, sram_wdata=0.
  - A read in flight at reset is dropped and never returned.
- Access issue:
  - The sram_* outputs are combinational from the grant. At most one access per cycle.
  - sram_en=1 only on a granted handshake.
  - sram_wdata and sram_addr come from the granted channel; both are 0 when idle.
- Read credit:
  - occ = response buffer occupancy (0..2); infl = read issued last cycle (0/1); pop = rresp_valid & rresp_ready.
  - read_ok = (occ + infl - pop) < 2.
- Arbitration:
  - Write alone valid: grant write.
  - Read alone valid: grant read if read_ok.
  - Both valid and read_ok: grant the channel the pointer favours, then flip the pointer to the other channel.
  - Both valid and !read_ok: grant write; the pointer is unchanged.
  - wreq_ready = grant_w; rreq_ready = grant_r. Either ready may depend on the other channel's valid. No valid depends on any ready.
- Read latency:
  - A read granted in cycle t sets infl for t+1.
  - At the end of t+1, sram_rdata is pushed into the response buffer.
  - rresp_valid is high from t+2 at the earliest; the buffer is registered and has no bypass.
- Ordering:
  - A write granted in cycle t is visible to a read granted at t+1 or later.
  - A read granted at t returns the pre-write value for a write to the same address granted at t+1, because capture occurs on the same edge as the write.
- Response buffer:
  - 2-entry FIFO; the head drives rresp_data (0 when empty).
  - Push and pop in the same cycle are allowed at any occupancy the credit rule permits.
  - Overflow is impossible by construction; assert !(push && occ==2 && !pop).
- Throughput: with rresp_ready held 1, back-to-back reads sustain 1 per cycle.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, an opcode constant (WMODE_READ=0, WMODE_WRITE=1), and a response-buffer depth constant RESP_DEPTH=2.
- One sub-module: sram_resp_fifo (2-entry valid/ready FIFO, async active-low reset, exposes occupancy).

Test Plan:
- Write addr 1 data 0x2_DEAD_BEEF_CAFE_F00D, then read addr 1 with rresp_ready=1: the read is granted the cycle after the write, and rresp_valid rises 2 cycles after the read grant with the same data.
- Four back-to-back reads of addrs 0..3 with rresp_ready=1: rreq_ready stays 1 every cycle, and responses arrive on 4 consecutive cycles in order.
- rresp_ready=0 with reads pending:
  - Exactly 2 reads are granted, then rreq_ready=0; rresp_valid holds the first response stably.
  - Raising rresp_ready drains in order, and reads resume the same cycle as the first pop.
- wreq_valid and rreq_valid held 1 for 6 cycles with credit available: grants alternate W,R,W,R,W,R starting with W after reset.
- Read addr 2 (old value A) granted at t, write addr 2 value B granted at t+1, read addr 2 at t+2: the responses are A then B.
- Assert reset_n=0 for 1 cycle while a read is in flight and one response is buffered:
  - All outputs are 0 immediately and stay 0 through reset.
  - After release, no stale response appears, and a new read returns correct data.
